// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : IF-stage instruction fetch buffer. Issues each PC to a
//                1-cycle-latency synchronous instruction memory, tracks the
//                single in-flight read, captures {pc, instr} into a
//                DEPTH-entry FIFO and presents the head entry to decode over
//                valid/ready. Raises fq_stall to freeze the PC counter on
//                back-pressure and drops all wrong-path state on an EX flush.
//  Ports       : clk, reset (async, active-high)
//                pc              - current PC from the PC counter
//                fq_stall        - hold the PC counter
//                ex_branch_flush - EX misprediction flush
//                imem_en/addr    - instruction memory read request
//                imem_rdata      - read data, one cycle after imem_en
//                deq_valid/ready - head entry handshake to decode
//                deq_pc/instr    - head entry payload
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int XLEN_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN_WIDTH-1:0]  pc,
    output logic                   fq_stall,
    input  logic                   ex_branch_flush,
    output logic                   imem_en,
    output logic [XLEN_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [XLEN_WIDTH-1:0]  deq_pc,
    output logic [INSTR_WIDTH-1:0] deq_instr
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]  c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    logic [XLEN_WIDTH-1:0]  r_mem_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_infl_valid;
    logic [XLEN_WIDTH-1:0]  r_infl_pc;

    logic                   w_issue;
    logic                   w_write;
    logic                   w_pop;
    logic [c_CNT_W:0]       w_occupancy;

    // The outstanding read holds a credit, so the stall is raised while the
    // slot it will land in is still free. Registers only: no path from
    // deq_ready or the flush into the PC counter's hold.
    assign w_occupancy = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_infl_valid};
    assign fq_stall    = (w_occupancy >= c_DEPTH);

    assign w_issue   = ~fq_stall & ~ex_branch_flush;
    // Gated by reset so no read is requested while the block is held.
    assign imem_en   = w_issue & ~reset;
    assign imem_addr = pc;

    // A flush kills the returning wrong-path response and blocks the pop.
    assign w_write   = r_infl_valid & ~ex_branch_flush;
    assign deq_valid = (r_count != '0) & ~ex_branch_flush;
    assign w_pop     = deq_valid & deq_ready;

    assign deq_pc    = r_mem_pc[r_rd_ptr];
    assign deq_instr = r_mem_instr[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_infl_valid <= 1'b0;
            r_infl_pc    <= '0;
        end else if (ex_branch_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_infl_valid <= 1'b0;
            r_infl_pc    <= pc;
        end else begin
            r_infl_valid <= w_issue;
            r_infl_pc    <= pc;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_pc[r_wr_ptr]    <= r_infl_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. Models the PC counter
//                and a 1-cycle synchronous instruction memory, then applies
//                per-cycle vectors of {inputs, expected outputs}, followed
//                by an asynchronous mid-stream reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] c_XOR = 32'hDEAD_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        fq_stall;
    logic        ex_branch_flush;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [31:0] target;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(
        .XLEN_WIDTH  (32),
        .INSTR_WIDTH (32),
        .DEPTH       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .fq_stall        (fq_stall),
        .ex_branch_flush (ex_branch_flush),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .deq_valid       (deq_valid),
        .deq_ready       (deq_ready),
        .deq_pc          (deq_pc),
        .deq_instr       (deq_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC counter: reset to 0, load target on flush, advance unless stalled.
    always @(posedge clk or posedge reset) begin
        if (reset)                pc <= 32'h0;
        else if (ex_branch_flush) pc <= target;
        else if (!fq_stall)       pc <= pc + 32'd4;
    end

    // Instruction memory: data is a fixed function of the address.
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ c_XOR;
    end

    typedef struct {
        bit          start;   // reset before this row
        bit          rdy;
        bit          fl;
        logic [31:0] tgt;
        bit          ev;      // expected deq_valid
        logic [31:0] epc;
        bit          es;      // expected fq_stall
        bit          een;     // expected imem_en
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit st, input bit r, input bit f, input logic [31:0] t,
                       input bit v, input logic [31:0] p, input bit s,
                       input bit e, input logic [31:0] a);
        vec_t x;
        x.start = st; x.rdy = r; x.fl = f; x.tgt = t;
        x.ev = v; x.epc = p; x.es = s; x.een = e; x.eaddr = a;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ex_branch_flush = 1'b0;
        deq_ready = 1'b0;
        #1;
        chk("reset deq_valid", 32'(deq_valid), 32'd0);
        chk("reset fq_stall",  32'(fq_stall),  32'd0);
        chk("reset imem_en",   32'(imem_en),   32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_rows_ready0();
        add(1,0,0,0, 0,0,     0, 1,32'h0);
        add(0,0,0,0, 0,0,     0, 1,32'h4);
        add(0,0,0,0, 1,32'h0, 0, 1,32'h8);
        add(0,0,0,0, 1,32'h0, 0, 1,32'hC);
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_flush = 1'b0;
        deq_ready = 1'b0;
        target = 32'h0;

        // Streaming with decode always ready: one entry per cycle from cycle 2.
        add(1,1,0,0, 0,0,     0, 1,32'h0);
        add(0,1,0,0, 0,0,     0, 1,32'h4);
        add(0,1,0,0, 1,32'h0, 0, 1,32'h8);
        add(0,1,0,0, 1,32'h4, 0, 1,32'hC);
        add(0,1,0,0, 1,32'h8, 0, 1,32'h10);
        add(0,1,0,0, 1,32'hC, 0, 1,32'h14);

        // Back-pressure until full, PC held at 0x10, then drain in order.
        fill_rows_ready0();
        add(0,0,0,0, 1,32'h0,  1, 0,32'h0);
        add(0,0,0,0, 1,32'h0,  1, 0,32'h0);
        add(0,1,0,0, 1,32'h0,  1, 0,32'h0);
        add(0,1,0,0, 1,32'h4,  0, 1,32'h10);
        add(0,1,0,0, 1,32'h8,  0, 1,32'h14);
        add(0,1,0,0, 1,32'hC,  0, 1,32'h18);
        add(0,1,0,0, 1,32'h10, 0, 1,32'h1C);
        add(0,1,0,0, 1,32'h14, 0, 1,32'h20);

        // Full queue, flush to 0x100 while stalled.
        fill_rows_ready0();
        add(0,0,0,0,          1,32'h0,   1, 0,32'h0);
        add(0,0,0,0,          1,32'h0,   1, 0,32'h0);
        add(0,1,1,32'h100,    0,0,       1, 0,32'h0);
        add(0,1,0,0,          0,0,       0, 1,32'h100);
        add(0,1,0,0,          0,0,       0, 1,32'h104);
        add(0,1,0,0,          1,32'h100, 0, 1,32'h108);
        add(0,1,0,0,          1,32'h104, 0, 1,32'h10C);

        // Flush while the read for 0x8 is returning.
        add(1,1,0,0,          0,0,       0, 1,32'h0);
        add(0,1,0,0,          0,0,       0, 1,32'h4);
        add(0,1,0,0,          1,32'h0,   0, 1,32'h8);
        add(0,1,1,32'h200,    0,0,       0, 0,32'h0);
        add(0,1,0,0,          0,0,       0, 1,32'h200);
        add(0,1,0,0,          0,0,       0, 1,32'h204);
        add(0,1,0,0,          1,32'h200, 0, 1,32'h208);

        // count=3: write+pop in the same cycle repeatedly across the wrap.
        fill_rows_ready0();
        add(0,1,0,0, 1,32'h0,  1, 0,32'h0);
        add(0,0,0,0, 1,32'h4,  0, 1,32'h10);
        add(0,1,0,0, 1,32'h4,  1, 0,32'h0);
        add(0,0,0,0, 1,32'h8,  0, 1,32'h14);
        add(0,1,0,0, 1,32'h8,  1, 0,32'h0);
        add(0,0,0,0, 1,32'hC,  0, 1,32'h18);
        add(0,1,0,0, 1,32'hC,  1, 0,32'h0);
        add(0,0,0,0, 1,32'h10, 0, 1,32'h1C);
        add(0,1,0,0, 1,32'h10, 1, 0,32'h0);
        add(0,0,0,0, 1,32'h14, 0, 1,32'h20);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].start) do_reset();
            else               @(negedge clk);
            deq_ready       = vecs[i].rdy;
            ex_branch_flush = vecs[i].fl;
            target          = vecs[i].tgt;
            #1;
            chk($sformatf("row%0d deq_valid", i), 32'(deq_valid), 32'(vecs[i].ev));
            chk($sformatf("row%0d fq_stall", i),  32'(fq_stall),  32'(vecs[i].es));
            chk($sformatf("row%0d imem_en", i),   32'(imem_en),   32'(vecs[i].een));
            if (vecs[i].een)
                chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("row%0d deq_pc", i),    deq_pc,    vecs[i].epc);
                chk($sformatf("row%0d deq_instr", i), deq_instr, vecs[i].epc ^ c_XOR);
            end
        end

        // Asynchronous reset between edges while full and stalled.
        do_reset();
        deq_ready = 1'b0;
        ex_branch_flush = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre-async deq_valid", 32'(deq_valid), 32'd1);
        chk("pre-async fq_stall",  32'(fq_stall),  32'd1);
        reset = 1'b1;
        #1;
        chk("async deq_valid", 32'(deq_valid), 32'd0);
        chk("async fq_stall",  32'(fq_stall),  32'd0);
        chk("async imem_en",   32'(imem_en),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        deq_ready = 1'b1;
        #1;
        chk("restart c0 imem_en",   32'(imem_en),   32'd1);
        chk("restart c0 imem_addr", imem_addr,      32'h0);
        chk("restart c0 deq_valid", 32'(deq_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("restart c1 deq_valid", 32'(deq_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("restart c2 deq_valid", 32'(deq_valid), 32'd1);
        chk("restart c2 deq_pc",    deq_pc,         32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
